// File: rtl/full_handshake_pkg.sv
// Shared types and constants for the four-phase CDC handshake (transmit and receive ends).
package full_handshake_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ASSERT   = 2'b01,
      DEASSERT = 2'b10
   } hs_tx_state_e;

   localparam int HS_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Multi-bit flop-chain synchronizer (HS_SYNC_STAGES deep), async active-low reset.
// Each bit is synchronized independently; only use for single-bit or gray-coded data.
module sync_2ff
   import full_handshake_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [HS_SYNC_STAGES-1:0][W-1:0] stage_r;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         stage_r <= {(HS_SYNC_STAGES*W){1'b0}};
      end else begin
         stage_r <= {stage_r[HS_SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage_r[HS_SYNC_STAGES-1];

endmodule

// File: rtl/full_handshake_tx.sv
// Transmit end of the four-phase req/ack CDC handshake.
// Optional one-entry holding buffer enabled by defining FULL_HANDSHAKE_TX_BUF_EN.
module full_handshake_tx
   import full_handshake_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          ready_o,
   output logic          req_o,
   output logic [DW-1:0] req_data_o,
   input  logic          ack_i,
   output logic          done_o,
   output logic          busy_o
);

   hs_tx_state_e  state_r;
   hs_tx_state_e  state_nxt_s;
   logic          req_r;
   logic          req_nxt_s;
   logic [DW-1:0] data_r;
   logic [DW-1:0] data_nxt_s;
   logic          done_r;
   logic          done_nxt_s;
   logic          ack_s;
   logic          accept_s;

`ifdef FULL_HANDSHAKE_TX_BUF_EN
   logic          buf_valid_r;
   logic          buf_valid_nxt_s;
   logic [DW-1:0] buf_data_r;
   logic [DW-1:0] buf_data_nxt_s;
`endif

   // ack_i is only ever consumed through this synchronizer.
   sync_2ff #(
      .W(1)
   ) u_ack_sync (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .d     (ack_i),
      .q     (ack_s)
   );

`ifdef FULL_HANDSHAKE_TX_BUF_EN
   assign ready_o = !buf_valid_r;
`else
   assign ready_o = (state_r == IDLE);
`endif

   assign accept_s = valid_i & ready_o;

   // Next-state, request and data sequencing for the four phases.
   always_comb begin
      state_nxt_s = state_r;
      req_nxt_s   = req_r;
      data_nxt_s  = data_r;
      done_nxt_s  = 1'b0;
`ifdef FULL_HANDSHAKE_TX_BUF_EN
      buf_valid_nxt_s = buf_valid_r;
      buf_data_nxt_s  = buf_data_r;
`endif
      case (state_r)
         IDLE: begin
`ifdef FULL_HANDSHAKE_TX_BUF_EN
            // A queued word always launches ahead of a new offer.
            if (buf_valid_r) begin
               data_nxt_s      = buf_data_r;
               req_nxt_s       = 1'b1;
               state_nxt_s     = ASSERT;
               buf_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
               data_nxt_s  = data_i;
               req_nxt_s   = 1'b1;
               state_nxt_s = ASSERT;
            end else begin
               req_nxt_s = 1'b0;
            end
`else
            if (accept_s) begin
               data_nxt_s  = data_i;
               req_nxt_s   = 1'b1;
               state_nxt_s = ASSERT;
            end else begin
               req_nxt_s = 1'b0;
            end
`endif
         end
         ASSERT: begin
            if (ack_s) begin
               req_nxt_s   = 1'b0;
               state_nxt_s = DEASSERT;
            end else begin
               req_nxt_s = 1'b1;
            end
         end
         DEASSERT: begin
            if (!ack_s) begin
               state_nxt_s = IDLE;
               done_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = DEASSERT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            req_nxt_s   = 1'b0;
         end
      endcase
`ifdef FULL_HANDSHAKE_TX_BUF_EN
      // Offers taken while a transfer is in flight are parked in the buffer.
      if (accept_s && (state_r != IDLE)) begin
         buf_valid_nxt_s = 1'b1;
         buf_data_nxt_s  = data_i;
      end else begin
         buf_data_nxt_s = buf_data_nxt_s;
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         req_r   <= 1'b0;
         data_r  <= {DW{1'b0}};
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         req_r   <= req_nxt_s;
         data_r  <= data_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

`ifdef FULL_HANDSHAKE_TX_BUF_EN
   // Holding buffer registers.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid_r <= 1'b0;
         buf_data_r  <= {DW{1'b0}};
      end else begin
         buf_valid_r <= buf_valid_nxt_s;
         buf_data_r  <= buf_data_nxt_s;
      end
   end
`endif

   assign req_o      = req_r;
   assign req_data_o = data_r;
   assign done_o     = done_r;
   assign busy_o     = (state_r != IDLE);

endmodule
